// File: rtl/coffee_bus_pkg.sv
// Shared types for the CPU/VGA memory arbiter: default widths, FSM state
// encoding and the owner status codes.
package coffee_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_ACC  = 3'd1,
    ST_CPU_WAIT = 3'd2,
    ST_CPU_DONE = 3'd3,
    ST_VGA_ACC  = 3'd4,
    ST_VGA_WAIT = 3'd5,
    ST_VGA_DONE = 3'd6
  } arb_state_t;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_VGA  = 2'b10;

  function automatic logic [1:0] owner_of(input arb_state_t st);
    logic [1:0] own;
    case (st)
      ST_CPU_ACC, ST_CPU_WAIT, ST_CPU_DONE: own = OWN_CPU;
      ST_VGA_ACC, ST_VGA_WAIT, ST_VGA_DONE: own = OWN_VGA;
      default:                              own = OWN_IDLE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of CPU grants taken while VGA was waiting; o_sat tells
// the arbiter that VGA must be served next.
module arb_streak_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = (MAX > 1) ? $clog2(MAX + 1) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_count;

  // Clear wins over increment; the count never passes MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < MAX_C)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_sat = (r_count >= MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single MMU port: CPU (read/write) has priority,
// the VGA fetcher (read-only) wins when urgent or after a bounded CPU streak.
module mem_arbiter
  import coffee_bus_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RD_LAT        = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuStall,
  input  logic              vgaReq,
  input  logic              vgaUrgent,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic [DATA_W-1:0] vgaRData,
  output logic              vgaAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWren,
  input  logic [DATA_W-1:0] memQ,
  input  logic              memBusy,
  output logic [1:0]        owner
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_vga_rdata;
  logic              w_grant_cpu;
  logic              w_grant_vga;
  logic              w_accept;
  logic              w_in_wait;
  logic              w_lat_done;
  logic              w_streak_sat;

  assign w_accept   = ((r_state == ST_CPU_ACC) || (r_state == ST_VGA_ACC)) && !memBusy;
  assign w_in_wait  = (r_state == ST_CPU_WAIT) || (r_state == ST_VGA_WAIT);
  assign w_lat_done = (r_lat_cnt == '0);

  arb_streak_counter #(
    .MAX (MAX_CPU_BURST)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_grant_cpu & vgaReq),
    .i_clr (w_grant_vga),
    .o_sat (w_streak_sat)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration and access sequencing; every grant passes through IDLE first.
  always_comb begin
    w_next      = r_state;
    w_grant_cpu = 1'b0;
    w_grant_vga = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vgaReq && vgaUrgent) begin
          w_grant_vga = 1'b1;
          w_next      = ST_VGA_ACC;
        end else if (cpuReq && vgaReq && w_streak_sat) begin
          w_grant_vga = 1'b1;
          w_next      = ST_VGA_ACC;
        end else if (cpuReq) begin
          w_grant_cpu = 1'b1;
          w_next      = ST_CPU_ACC;
        end else if (vgaReq) begin
          w_grant_vga = 1'b1;
          w_next      = ST_VGA_ACC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CPU_ACC: begin
        if (memBusy) begin
          w_next = ST_CPU_ACC;
        end else if (r_we) begin
          w_next = ST_CPU_DONE;
        end else begin
          w_next = ST_CPU_WAIT;
        end
      end
      ST_CPU_WAIT: begin
        if (w_lat_done) begin
          w_next = ST_CPU_DONE;
        end else begin
          w_next = ST_CPU_WAIT;
        end
      end
      ST_VGA_ACC: begin
        if (memBusy) begin
          w_next = ST_VGA_ACC;
        end else begin
          w_next = ST_VGA_WAIT;
        end
      end
      ST_VGA_WAIT: begin
        if (w_lat_done) begin
          w_next = ST_VGA_DONE;
        end else begin
          w_next = ST_VGA_WAIT;
        end
      end
      ST_CPU_DONE: w_next = ST_IDLE;
      ST_VGA_DONE: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Request latching, read-latency countdown and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_lat_cnt   <= '0;
      r_cpu_rdata <= '0;
      r_vga_rdata <= '0;
    end else begin
      if (w_grant_cpu) begin
        r_addr  <= cpuAddr;
        r_wdata <= cpuWData;
        r_we    <= cpuWe;
      end else if (w_grant_vga) begin
        r_addr  <= vgaAddr;
        r_wdata <= '0;
        r_we    <= 1'b0;
      end
      if (w_accept) begin
        r_lat_cnt <= LAT_LOAD;
      end else if (w_in_wait && !w_lat_done) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
      if ((r_state == ST_CPU_WAIT) && w_lat_done) begin
        r_cpu_rdata <= memQ;
      end
      if ((r_state == ST_VGA_WAIT) && w_lat_done) begin
        r_vga_rdata <= memQ;
      end
    end
  end

  assign memAddr  = r_addr;
  assign memWData = r_wdata;
  assign memWren  = (r_state == ST_CPU_ACC) && r_we;
  assign cpuStall = cpuReq && (r_state != ST_CPU_DONE);
  assign cpuRData = r_cpu_rdata;
  assign vgaRData = r_vga_rdata;
  assign vgaAck   = (r_state == ST_VGA_DONE);
  assign owner    = owner_of(r_state);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with an MMU model of RD_LAT
// read latency and a scoreboard memory for CPU/VGA data.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst;
  logic          cpuReq, cpuWe, cpuStall;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWData, cpuRData;
  logic          vgaReq, vgaUrgent, vgaAck;
  logic [AW-1:0] vgaAddr;
  logic [DW-1:0] vgaRData;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData, memQ;
  logic          memWren, memBusy;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .RD_LAT (LAT), .MAX_CPU_BURST (MAXB)
  ) dut (
    .clk (clk), .rst (rst),
    .cpuReq (cpuReq), .cpuWe (cpuWe), .cpuAddr (cpuAddr), .cpuWData (cpuWData),
    .cpuRData (cpuRData), .cpuStall (cpuStall),
    .vgaReq (vgaReq), .vgaUrgent (vgaUrgent), .vgaAddr (vgaAddr),
    .vgaRData (vgaRData), .vgaAck (vgaAck),
    .memAddr (memAddr), .memWData (memWData), .memWren (memWren),
    .memQ (memQ), .memBusy (memBusy), .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of never-written locations; 0x20 holds the classic test pattern.
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h20) return 32'h1234_5678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // MMU model: writes land on an unstalled wren; memQ shows the location
  // addressed RD_LAT cycles earlier.
  bit [DW-1:0] mem_model [0:255];
  bit [255:0]  written;
  bit [7:0]    addr_pipe [0:LAT-1];

  always @(posedge clk) begin
    if (memWren && !memBusy) begin
      mem_model[memAddr[7:0]] <= memWData;
      written[memAddr[7:0]]   <= 1'b1;
    end
    addr_pipe[0] <= memAddr[7:0];
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  assign memQ = written[addr_pipe[LAT-1]] ? mem_model[addr_pipe[LAT-1]]
                                          : init_val(addr_pipe[LAT-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state for the random phase.
  bit [DW-1:0] ref_mem [0:255];
  bit          cpu_pend, vga_pend, c_we;
  int          c_addr, v_addr, cpu_since, vga_reqs, vga_acks;
  bit [DW-1:0] c_wd;

  task automatic observe();
    chk("wren_vga", {63'd0, memWren && (owner == 2'b10)}, 64'd0);
    if (cpu_pend && !cpuStall) begin
      if (c_we) ref_mem[c_addr] = c_wd;
      else chk("rnd_cpu_rd", cpuRData, ref_mem[c_addr]);
      cpu_pend = 1'b0;
      if (vga_pend) cpu_since++;
    end
    if (vgaAck) begin
      chk("rnd_ack_pend", {63'd0, vga_pend}, 64'd1);
      chk("rnd_vga_rd", vgaRData, ref_mem[v_addr]);
      chk("rnd_burst", {63'd0, cpu_since <= MAXB + 1}, 64'd1);
      vga_pend  = 1'b0;
      cpu_since = 0;
      vga_acks++;
    end
  endtask

  initial begin
    int ev;
    int cyc;
    rst = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
    vgaReq = 1'b0; vgaUrgent = 1'b0; vgaAddr = '0; memBusy = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_owner", owner, 2'b00);
    chk("rst_outs", {cpuStall, vgaAck, memWren, memAddr, memWData}, 64'd0);
    chk("rst_rdata", {cpuRData, vgaRData}, 64'd0);
    rst = 1'b0;

    // CPU write: wren only in cycle 1, stall low in cycle 2.
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0010; cpuWData = 32'hDEAD_BEEF;
    #1 chk("wr_c0_stall", cpuStall, 1'b1);
    chk("wr_c0_wren", memWren, 1'b0);
    @(negedge clk);
    chk("wr_c1_wren", memWren, 1'b1);
    chk("wr_c1_addr", memAddr, 16'h0010);
    chk("wr_c1_data", memWData, 32'hDEAD_BEEF);
    chk("wr_c1_owner", owner, 2'b01);
    chk("wr_c1_stall", cpuStall, 1'b1);
    @(negedge clk);
    chk("wr_c2_stall", cpuStall, 1'b0);
    chk("wr_c2_wren", memWren, 1'b0);
    chk("wr_mem", mem_model[8'h10], 32'hDEAD_BEEF);
    cpuReq = 1'b0; cpuWe = 1'b0;
    ref_mem[8'h10] = 32'hDEAD_BEEF;

    // CPU read, no MMU stall: low at 2+RD_LAT.
    @(negedge clk);
    cpuReq = 1'b1; cpuAddr = 16'h0020;
    #1 chk("rd_c0_stall", cpuStall, 1'b1);
    for (int k = 1; k <= 1 + LAT; k++) begin
      @(negedge clk);
      chk("rd_stall_hi", cpuStall, 1'b1);
    end
    @(negedge clk);
    chk("rd_stall_lo", cpuStall, 1'b0);
    chk("rd_data", cpuRData, 32'h1234_5678);
    cpuReq = 1'b0;

    // CPU read with memBusy held for 3 ACC cycles; later input changes ignored.
    @(negedge clk);
    cpuReq = 1'b1; cpuAddr = 16'h0024; memBusy = 1'b1;
    for (int k = 1; k <= 4 + LAT; k++) begin
      @(negedge clk);
      chk("bsy_stall_hi", cpuStall, 1'b1);
      if (k <= 4) chk("bsy_addr_hold", memAddr, 16'h0024);
      if (k == 1) cpuAddr = 16'h00FF;
      if (k == 4) memBusy = 1'b0;
    end
    @(negedge clk);
    chk("bsy_stall_lo", cpuStall, 1'b0);
    chk("bsy_data", cpuRData, init_val(8'h24));
    cpuReq = 1'b0;

    // Reset in the middle of VGA_WAIT aborts the access.
    @(negedge clk);
    vgaReq = 1'b1; vgaAddr = 16'h0100;
    @(negedge clk);
    chk("mid_c1_owner", owner, 2'b10);
    @(negedge clk);
    chk("mid_c2_owner", owner, 2'b10);
    rst = 1'b1;
    #1 chk("mid_rst_owner", owner, 2'b00);
    chk("mid_rst_outs", {cpuStall, vgaAck, memWren, memAddr, memWData}, 64'd0);
    chk("mid_rst_rdata", {cpuRData, vgaRData}, 64'd0);
    vgaReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * LAT + 4; k++) begin
      @(negedge clk);
      chk("mid_no_ack", vgaAck, 1'b0);
    end

    // Simultaneous requests, VGA urgent: VGA first, then CPU.
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0030;
    vgaReq = 1'b1; vgaUrgent = 1'b1; vgaAddr = 16'h0031;
    for (int k = 1; k <= 5 + 2 * LAT; k++) begin
      @(negedge clk);
      if (k == 1) chk("urg_owner", owner, 2'b10);
      chk("urg_ack", vgaAck, (k == 2 + LAT));
      chk("urg_stall", cpuStall, (k < 5 + 2 * LAT));
      if (vgaAck) begin
        chk("urg_vdata", vgaRData, init_val(8'h31));
        vgaReq = 1'b0; vgaUrgent = 1'b0;
      end
    end
    chk("urg_cdata", cpuRData, init_val(8'h30));
    cpuReq = 1'b0;

    // Both requesting continuously: CPU x MAXB, then VGA, repeating.
    @(negedge clk);
    cpuReq = 1'b1; cpuAddr = 16'h0040; vgaReq = 1'b1; vgaAddr = 16'h0041;
    ev = 0; cyc = 0;
    while (ev < 2 * (MAXB + 1) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!cpuStall) begin
        chk("fair_cpu_slot", {63'd0, (ev % (MAXB + 1)) != MAXB}, 64'd1);
        ev++;
      end
      if (vgaAck) begin
        chk("fair_vga_slot", {63'd0, (ev % (MAXB + 1)) == MAXB}, 64'd1);
        ev++;
      end
    end
    chk("fair_events", ev, 2 * (MAXB + 1));
    cpuReq = 1'b0; vgaReq = 1'b0;
    repeat (2 * LAT + 6) @(negedge clk);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 256; i++) ref_mem[i] = written[i] ? mem_model[i] : init_val(8'(i));
    cpu_pend = 1'b0; vga_pend = 1'b0; cpu_since = 0; vga_reqs = 0; vga_acks = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      observe();
      if (!cpu_pend && ($urandom_range(0, 3) != 0)) begin
        cpu_pend = 1'b1;
        c_we     = ($urandom_range(0, 1) == 1);
        c_addr   = $urandom_range(0, 31);
        c_wd     = $urandom;
        cpuWe    = c_we; cpuAddr = 16'(c_addr); cpuWData = c_wd;
      end
      cpuReq = cpu_pend;
      if (!vga_pend && ($urandom_range(0, 2) == 0)) begin
        vga_pend = 1'b1;
        v_addr   = $urandom_range(0, 31);
        vgaAddr  = 16'(v_addr);
        vga_reqs++;
      end
      vgaReq    = vga_pend;
      vgaUrgent = vga_pend && ($urandom_range(0, 9) == 0);
      memBusy   = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 300 && (cpu_pend || vga_pend); c++) begin
      @(negedge clk);
      observe();
      cpuReq = cpu_pend; vgaReq = vga_pend; vgaUrgent = 1'b0;
      memBusy = ($urandom_range(0, 3) == 0);
    end
    chk("rnd_drain", {62'd0, cpu_pend, vga_pend}, 64'd0);
    chk("rnd_ack_count", vga_acks, vga_reqs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
